// File: rtl/maze_bot_pkg.sv
// Shared types and constants for the maze bot MIPS I/O bridge:
// direction/speed codes, register map, STATUS bit positions and sequencer states.
package maze_bot_pkg;

   typedef enum logic [2:0] {
      NORTH, NORTHEAST, EAST, SOUTHEAST, SOUTH, SOUTHWEST, WEST, NORTHWEST
   } dir_e;

   typedef enum logic [1:0] {
      SPD_IDLE, SPD_SLOWEST, SPD_SLOW, SPD_FAST
   } spd_e;

   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_CMD     = 3'd1;
   localparam logic [2:0] REG_STATUS  = 3'd2;
   localparam logic [2:0] REG_MOVECNT = 3'd3;
   localparam logic [2:0] REG_IRQEN   = 3'd4;

   localparam int CMD_SRST  = 0;
   localparam int CMD_CLEAR = 1;

   localparam int ST_DEADLOCK = 16;
   localparam int ST_WALL     = 17;
   localparam int ST_END      = 18;
   localparam int ST_MOVED    = 19;
   localparam int ST_BUSY     = 20;

   // Bot location seen straight after a hard reset.
   localparam logic [7:0] RESET_LOCX = 8'd68;
   localparam logic [7:0] RESET_LOCY = 8'd60;

   typedef enum logic [1:0] {
      SRST_IDLE, SRST_ASSERT, SRST_SETTLE
   } srst_state_e;

   function automatic logic [31:0] pack_ctrl(input logic [2:0] dir,
                                             input logic [1:0] xspd,
                                             input logic [1:0] yspd);
      return {22'd0, yspd, 2'd0, xspd, 1'b0, dir};
   endfunction

endpackage

// File: rtl/maze_bot_io_if.sv
// MIPS I/O bus slice seen by the maze bot register bridge.
// Handshake: bus_we/bus_re are one-cycle strobes; bus_ack pulses exactly one cycle later
// with bus_rdata registered alongside it (0 for writes or when no read is acknowledged).
interface maze_bot_io_if;
   logic [2:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_addr, bus_wdata, bus_we, bus_re,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_addr, bus_wdata, bus_we, bus_re,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/maze_bot_srst_seq.sv
// Soft-reset sequencer: holds soft_rst_n low for SRST_CYCLES clocks, then one
// settle cycle that pulses done before returning to idle.
module maze_bot_srst_seq
   import maze_bot_pkg::*;
#(
   parameter int SRST_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        soft_rst_n,
   output logic        busy,
   output logic        done,
   output srst_state_e state
);

   localparam int CNT_W = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

   srst_state_e      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= SRST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A start seen outside IDLE is dropped, so a busy sequence never restarts.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      soft_rst_n = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         SRST_IDLE: begin
            if (start) begin
               state_nxt = SRST_ASSERT;
               cnt_nxt   = CNT_W'(SRST_CYCLES - 1);
            end
         end
         SRST_ASSERT: begin
            soft_rst_n = 1'b0;
            busy       = 1'b1;
            if (cnt == '0) state_nxt = SRST_SETTLE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         SRST_SETTLE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = SRST_IDLE;
         end
         default: state_nxt = SRST_IDLE;
      endcase
   end

endmodule

// File: rtl/maze_bot_io.sv
// Memory-mapped register bridge between the MIPS I/O decoder and the maze bot:
// control/command registers, sticky event flags, move counter and level interrupt.
module maze_bot_io
   import maze_bot_pkg::*;
#(
   parameter int SRST_CYCLES = 4,
   parameter int MOVECNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   maze_bot_io_if.slave       bus,
   output logic [2:0]         bot_dir,
   output logic [1:0]         bot_xspd,
   output logic [1:0]         bot_yspd,
   output logic               soft_rst_n,
   input  logic [7:0]         bot_locx,
   input  logic [7:0]         bot_locy,
   input  logic               bot_end,
   input  logic               bot_wall,
   input  logic               bot_deadlock,
   output logic               irq,
   output srst_state_e        srst_state
);

   logic [2:0]           ctrl_dir;
   logic [1:0]           ctrl_xspd;
   logic [1:0]           ctrl_yspd;
   logic [2:0]           irq_en;
   logic                 wall_stk, end_stk, moved_stk;
   logic                 wall_q, end_q;
   logic [7:0]           prev_locx, prev_locy;
   logic [MOVECNT_W-1:0] movecnt;
   logic [31:0]          rdata_nxt;

   logic wr, rd, wr_ctrl, wr_cmd, wr_irqen, rd_status;
   logic srst_start, sw_clear, srst_busy, srst_done, idle;
   logic wall_rise, end_rise, move, clr_all, clr_flags;

   assign wr        = bus.bus_we;
   assign rd        = bus.bus_re & ~bus.bus_we;
   assign wr_ctrl   = wr && (bus.bus_addr == REG_CTRL);
   assign wr_cmd    = wr && (bus.bus_addr == REG_CMD);
   assign wr_irqen  = wr && (bus.bus_addr == REG_IRQEN);
   assign rd_status = rd && (bus.bus_addr == REG_STATUS);

   assign srst_start = wr_cmd & bus.bus_wdata[CMD_SRST];
   assign sw_clear   = wr_cmd & bus.bus_wdata[CMD_CLEAR];

   maze_bot_srst_seq #(.SRST_CYCLES(SRST_CYCLES)) u_srst (
      .clk        (clk),
      .rst        (rst),
      .start      (srst_start),
      .soft_rst_n (soft_rst_n),
      .busy       (srst_busy),
      .done       (srst_done),
      .state      (srst_state)
   );

   assign idle = ~srst_busy;

   // Events and moves are only meaningful while the bot is out of soft reset.
   assign wall_rise = bot_wall & ~wall_q & idle;
   assign end_rise  = bot_end  & ~end_q  & idle;
   assign move      = ({bot_locx, bot_locy} != {prev_locx, prev_locy}) & ~bot_deadlock & idle;

   assign clr_all   = sw_clear | srst_done;
   assign clr_flags = clr_all | rd_status;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_dir  <= '0;
         ctrl_xspd <= '0;
         ctrl_yspd <= '0;
         irq_en    <= '0;
         wall_stk  <= 1'b0;
         end_stk   <= 1'b0;
         moved_stk <= 1'b0;
         wall_q    <= 1'b0;
         end_q     <= 1'b0;
         prev_locx <= RESET_LOCX;
         prev_locy <= RESET_LOCY;
         movecnt   <= '0;
         irq       <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_dir  <= bus.bus_wdata[2:0];
            ctrl_xspd <= bus.bus_wdata[5:4];
            ctrl_yspd <= bus.bus_wdata[9:8];
         end
         if (wr_irqen) irq_en <= bus.bus_wdata[2:0];

         wall_q    <= bot_wall;
         end_q     <= bot_end;
         prev_locx <= bot_locx;
         prev_locy <= bot_locy;

         // A flag set in the same cycle as a clear survives the clear.
         wall_stk  <= (wall_stk  & ~clr_flags) | wall_rise;
         end_stk   <= (end_stk   & ~clr_flags) | end_rise;
         moved_stk <= (moved_stk & ~clr_flags) | move;

         if (clr_all)
            movecnt <= move ? MOVECNT_W'(1) : '0;
         else if (move && (movecnt != {MOVECNT_W{1'b1}}))
            movecnt <= movecnt + MOVECNT_W'(1);

         irq <= |({moved_stk, end_stk, wall_stk} & irq_en);
      end
   end

   always_comb begin
      rdata_nxt = '0;
      case (bus.bus_addr)
         REG_CTRL:    rdata_nxt = pack_ctrl(ctrl_dir, ctrl_xspd, ctrl_yspd);
         REG_STATUS: begin
            rdata_nxt[7:0]         = bot_locx;
            rdata_nxt[15:8]        = bot_locy;
            rdata_nxt[ST_DEADLOCK] = bot_deadlock;
            rdata_nxt[ST_WALL]     = wall_stk;
            rdata_nxt[ST_END]      = end_stk;
            rdata_nxt[ST_MOVED]    = moved_stk;
            rdata_nxt[ST_BUSY]     = srst_busy;
         end
         REG_MOVECNT: rdata_nxt = 32'(movecnt);
         REG_IRQEN:   rdata_nxt = {29'd0, irq_en};
         default:     rdata_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.bus_ack   <= 1'b0;
         bus.bus_rdata <= '0;
      end else begin
         bus.bus_ack   <= bus.bus_we | bus.bus_re;
         bus.bus_rdata <= rd ? rdata_nxt : '0;
      end
   end

   assign bot_dir  = ctrl_dir;
   assign bot_xspd = idle ? ctrl_xspd : SPD_IDLE;
   assign bot_yspd = idle ? ctrl_yspd : SPD_IDLE;

   logic unused_wdata;
   assign unused_wdata = ^{bus.bus_wdata[31:10], bus.bus_wdata[7:6], bus.bus_wdata[3]};

endmodule
